// File: rtl/bip_control_if.sv
// Bus between the bip_control sequencer and the fetch port, data memory and datapath.
// The master modport is the control unit's view of the bus.
interface bip_control_if #(
    parameter int DATA_WIDTH   = 11,
    parameter int OPCODE_WIDTH = 5
);
    logic                               instr_req_out;
    logic [DATA_WIDTH-1:0]              instr_addr_out;
    logic                               instr_valid_in;
    logic [OPCODE_WIDTH+DATA_WIDTH-1:0] instr_data_in;
    logic [DATA_WIDTH-1:0]              operand_out;
    logic                               mem_rd_out;
    logic                               mem_wr_out;
    logic                               mem_ready_in;
    logic                               operation_out;
    logic                               b_sel_out;
    logic                               acc_wr_out;
    logic [1:0]                         acc_src_out;
    logic                               halted_out;
    logic                               error_out;

    modport master (
        output instr_req_out, instr_addr_out,
        input  instr_valid_in, instr_data_in,
        output operand_out, mem_rd_out, mem_wr_out,
        input  mem_ready_in,
        output operation_out, b_sel_out, acc_wr_out, acc_src_out,
        output halted_out, error_out
    );

    modport slave (
        input  instr_req_out, instr_addr_out,
        output instr_valid_in, instr_data_in,
        input  operand_out, mem_rd_out, mem_wr_out,
        output mem_ready_in,
        input  operation_out, b_sel_out, acc_wr_out, acc_src_out,
        input  halted_out, error_out
    );
endinterface

// File: rtl/bip_control.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator processor.
// Optional wait watchdog enabled by defining CTRL_TIMEOUT_EN.
module bip_control #(
    parameter int DATA_WIDTH     = 11,
    parameter int OPCODE_WIDTH   = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clock_in,
    input  logic          reset_in,
    bip_control_if.master bus
);
    localparam int IW = OPCODE_WIDTH + DATA_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [IW-1:0]         ir_q, ir_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;

    logic                  req_q, req_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  opn_q, opn_d;
    logic                  bsel_q, bsel_d;
    logic                  accwr_q, accwr_d;
    logic [1:0]            src_q, src_d;
    logic                  halt_q, halt_d;

    logic                  op_rd, op_wr, op_acc, op_sub, op_imm;

    assign op_q = ir_q[IW-1 -: OPCODE_WIDTH];
    assign op_d = ir_d[IW-1 -: OPCODE_WIDTH];

`ifdef CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_q;
    logic          to_hit;
    logic          err_q;
    logic          wait_lim;

    assign wait_lim = (wait_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Next-state, PC and IR.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
`ifdef CTRL_TIMEOUT_EN
        to_hit  = 1'b0;
`endif
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.instr_valid_in) begin
                    ir_d    = bus.instr_data_in;
                    state_d = S_DECODE;
                end
`ifdef CTRL_TIMEOUT_EN
                else if (wait_lim) begin
                    state_d = S_HALT;
                    to_hit  = 1'b1;
                end
`endif
            end
            S_DECODE: begin
                case (op_q)
                    OP_HLT:                         state_d = S_HALT;
                    OP_STO, OP_LD, OP_ADD, OP_SUB:  state_d = S_MEM;
                    default:                        state_d = S_EXEC;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready_in) begin
                    state_d = S_EXEC;
                end
`ifdef CTRL_TIMEOUT_EN
                else if (wait_lim) begin
                    state_d = S_HALT;
                    to_hit  = 1'b1;
                end
`endif
            end
            S_EXEC: begin
                pc_d    = pc_q + DATA_WIDTH'(1);
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Opcode classes, taken from the IR value the next state will see.
    always_comb begin
        op_rd  = (op_d == OP_LD) || (op_d == OP_ADD) || (op_d == OP_SUB);
        op_wr  = (op_d == OP_STO);
        op_acc = (op_d == OP_LD)  || (op_d == OP_LDI) ||
                 (op_d == OP_ADD) || (op_d == OP_ADDI) ||
                 (op_d == OP_SUB) || (op_d == OP_SUBI);
        op_sub = (op_d == OP_SUB) || (op_d == OP_SUBI);
        op_imm = (op_d == OP_ADDI) || (op_d == OP_SUBI);
    end

    // Outputs are computed from the next state so the flops line up with state_q.
    always_comb begin
        req_d   = (state_d == S_FETCH);
        rd_d    = (state_d == S_MEM) && op_rd;
        wr_d    = (state_d == S_MEM) && op_wr;
        opn_d   = ((state_d == S_MEM) || (state_d == S_EXEC)) && op_sub;
        bsel_d  = ((state_d == S_MEM) || (state_d == S_EXEC)) && op_imm;
        accwr_d = (state_d == S_EXEC) && op_acc;
        src_d   = 2'b00;
        if (state_d == S_EXEC) begin
            if (op_d == OP_LD)       src_d = 2'b01;
            else if (op_d == OP_LDI) src_d = 2'b10;
        end
        halt_d  = (state_d == S_HALT);
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            req_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            opn_q   <= 1'b0;
            bsel_q  <= 1'b0;
            accwr_q <= 1'b0;
            src_q   <= 2'b00;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            req_q   <= req_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            opn_q   <= opn_d;
            bsel_q  <= bsel_d;
            accwr_q <= accwr_d;
            src_q   <= src_d;
            halt_q  <= halt_d;
        end
    end

`ifdef CTRL_TIMEOUT_EN
    // Counts consecutive stalled cycles; any state change restarts it.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_d != state_q)
                wait_q <= '0;
            else if ((state_q == S_FETCH) || (state_q == S_MEM))
                wait_q <= wait_q + CW'(1);
            if (to_hit)
                err_q <= 1'b1;
        end
    end

    assign bus.error_out = err_q;
`else
    assign bus.error_out = 1'b0;
`endif

    assign bus.instr_req_out  = req_q;
    assign bus.instr_addr_out = pc_q;
    assign bus.operand_out    = ir_q[DATA_WIDTH-1:0];
    assign bus.mem_rd_out     = rd_q;
    assign bus.mem_wr_out     = wr_q;
    assign bus.operation_out  = opn_q;
    assign bus.b_sel_out      = bsel_q;
    assign bus.acc_wr_out     = accwr_q;
    assign bus.acc_src_out    = src_q;
    assign bus.halted_out     = halt_q;
endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Multi-cycle control unit for the accumulator processor.
- Each instruction is fetched, decoded and executed in sequence.
- Drives the ALU `operation` select, the B-operand mux, the accumulator write enable and source, and the data-memory read/write strobes.
- Owns the program counter (PC). Feeds the ALU and accumulator directly.

Parameters:
- DATA_WIDTH, 11: operand, address and PC width. Matches the ALU data width.
- OPCODE_WIDTH, 5: opcode field width.
- TIMEOUT_CYCLES, 64: wait limit, used only with CTRL_TIMEOUT_EN.

Ports:
- clock_in  in  1  system clock; all state changes on its rising edge
- reset_in  in  1  synchronous, active-high reset
- instr_req_out  out  1  instruction fetch request
- instr_addr_out  out  DATA_WIDTH  fetch address (= PC)
- instr_valid_in  in  1  instruction word valid
- instr_data_in  in  OPCODE_WIDTH+DATA_WIDTH  {opcode, operand}
- operand_out  out  DATA_WIDTH  operand field of IR: immediate value or data-memory address
- mem_rd_out  out  1  data-memory read strobe
- mem_wr_out  out  1  data-memory write strobe (stores accumulator)
- mem_ready_in  in  1  data-memory access complete
- operation_out  out  1  to ALU: 0 = add, 1 = subtract
- b_sel_out  out  1  ALU B operand: 0 = memory data, 1 = operand_out
- acc_wr_out  out  1  accumulator write enable, one-cycle pulse
- acc_src_out  out  2  accumulator source: 00 ALU, 01 memory data, 10 operand_out
- halted_out  out  1  processor halted
- error_out  out  1  timeout flag (0 unless CTRL_TIMEOUT_EN)

Behaviour:
- Clock and reset: one clock, clock_in. Reset is synchronous and active-high on reset_in.
- Reset state: every output, the PC and the IR are 0. FSM enters IDLE.
- Outputs are registered functions of state and IR.
- Reset wins over every other event, including mid-handshake. The FSM abandons any pending fetch or memory access. Strobes are low from the first clock after reset is sampled.
- Opcodes:
  - 00000 HLT
  - 00001 STO
  - 00010 LD
  - 00011 LDI
  - 00100 ADD
  - 00101 ADDI
  - 00110 SUB
  - 00111 SUBI
  - All others execute as NOP: PC advances, no side effects.
- FSM states:
  - IDLE: go to FETCH next cycle.
  - FETCH: instr_req_out = 1 and instr_addr_out = PC. Hold until instr_valid_in = 1, then latch the IR, drop the request and go to DECODE. instr_valid_in outside FETCH is ignored.
  - DECODE (1 cycle):
    - HLT goes to HALT.
    - STO, LD, ADD and SUB go to MEM.
    - All others go to EXEC.
  - MEM:
    - mem_wr_out = 1 for STO. mem_rd_out = 1 for LD, ADD and SUB.
    - Strobe is held until mem_ready_in = 1, then goes to EXEC.
    - mem_ready_in outside MEM is ignored.
  - EXEC (1 cycle):
    - acc_wr_out = 1 except for STO and NOP.
    - acc_src_out: 01 for LD, 10 for LDI, 00 for ADD, ADDI, SUB and SUBI.
    - operation_out = 1 for SUB and SUBI, else 0.
    - b_sel_out = 1 for ADDI and SUBI, else 0.
    - PC <= PC+1, then go to FETCH.
  - HALT: halted_out = 1, no strobes, PC frozen. Exit only via reset.
- Timing and arithmetic:
  - operation_out and b_sel_out are also valid during MEM, so ALU inputs settle before the EXEC write.
  - PC wraps from 2^DATA_WIDTH-1 to 0 with no flag.
  - Minimum latency, fetch to acc write: immediate ops 3 cycles (FETCH, DECODE, EXEC); memory ops 4 cycles (plus wait cycles).
  - Strobes are never asserted simultaneously.

Optional Feature:
- Macro: CTRL_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) counts consecutive wait cycles in FETCH or MEM, and clears on state change.
  - After TIMEOUT_CYCLES cycles without instr_valid_in or mem_ready_in, the FSM drops its strobe, enters HALT and sets error_out = 1.
  - error_out is sticky until reset.
- When undefined: no counter logic, waits are unbounded, error_out is tied 0.

Test Plan:
- Reset, then LDI 5 with zero-wait fetch: acc_wr_out pulses in cycle 3 after fetch start with acc_src_out = 10 and operand_out = 5. PC then reads 1.
- ADD from address 0x012 with mem_ready_in delayed 3 cycles: mem_rd_out is held 4 cycles. Then the EXEC pulse shows operation_out = 0, b_sel_out = 0 and acc_src_out = 00.
- SUBI 7: EXEC shows operation_out = 1, b_sel_out = 1 and acc_wr_out = 1. mem_rd_out and mem_wr_out stay 0 throughout.
- STO 0x3FF, then HLT: mem_wr_out is high until ready, with no acc_wr_out. After HLT, halted_out = 1 and instr_req_out stays 0 for 20 cycles. Reset restarts the fetch at PC 0.
- PC at 0x7FF executing NOP: next instr_addr_out = 0x000. Pulsing reset_in mid-MEM: strobes drop next cycle and all outputs are 0.
- With CTRL_TIMEOUT_EN and TIMEOUT_CYCLES = 4, instr_valid_in held 0: after 4 wait cycles, instr_req_out = 0, halted_out = 1 and error_out = 1.
